// File: rtl/nibble_parity_rx_pkg.sv
// rtl/nibble_parity_rx_pkg.sv - shared state encodings and frame constants for the nibble receiver
package nibble_parity_rx_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int DATA_BITS  = 4;
    localparam int FRAME_BITS = 7;

endpackage

// File: rtl/nibble_parity_rx_parity4.sv
// rtl/nibble_parity_rx_parity4.sv - combinational 4-input XOR, shared with the transmit side
module nibble_parity_rx_parity4 (
    input  logic [3:0] data,
    output logic       parity
);

    assign parity = ^data;

endmodule

// File: rtl/nibble_parity_rx.sv
// rtl/nibble_parity_rx.sv - start/4 data/parity/stop deserialiser with a one-entry valid/ready buffer
module nibble_parity_rx
    import nibble_parity_rx_pkg::*;
#(
    parameter logic ODD_PARITY = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_en,
    input  logic                 sin,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_par_err,
    output logic                 out_frm_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overrun
);

    logic [1:0]           state;
    logic [1:0]           cnt;
    logic [DATA_BITS-1:0] sreg;
    logic                 par_bit;
    logic                 data_xor;
    logic                 par_err;
    logic                 frame_done;

    nibble_parity_rx_parity4 u_parity4 (
        .data   (sreg),
        .parity (data_xor)
    );

    assign par_err    = (data_xor ^ par_bit) != ODD_PARITY;
    assign frame_done = bit_en && (state == ST_STOP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= 2'd0;
            sreg        <= '0;
            par_bit     <= 1'b0;
            out_data    <= '0;
            out_par_err <= 1'b0;
            out_frm_err <= 1'b0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;

            if (bit_en) begin
                case (state)
                    ST_IDLE: begin
                        if (!sin) begin
                            state <= ST_DATA;
                            cnt   <= 2'd0;
                        end
                    end
                    ST_DATA: begin
                        sreg[cnt] <= sin;
                        if (cnt == 2'(DATA_BITS - 1)) begin
                            state <= ST_PARITY;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= sin;
                        state   <= ST_STOP;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end

            // A completing frame may reuse the slot if it is being drained on this same edge.
            if (frame_done) begin
                if (!out_valid || out_ready) begin
                    out_data    <= sreg;
                    out_par_err <= par_err;
                    out_frm_err <= ~sin;
                    out_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nibble_parity_rx.sv
// tb/tb_nibble_parity_rx.sv - self-checking bench for nibble_parity_rx (even and odd parity instances)
module tb_nibble_parity_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en = 1'b0;
    logic       sin = 1'b1;
    logic       out_ready = 1'b1;

    logic [3:0] e_data, o_data;
    logic       e_perr, o_perr, e_ferr, o_ferr, e_valid, o_valid, e_ovr, o_ovr;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 1'b0;

    nibble_parity_rx #(.ODD_PARITY(1'b0)) dut_even (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sin(sin),
        .out_data(e_data), .out_par_err(e_perr), .out_frm_err(e_ferr),
        .out_valid(e_valid), .out_ready(out_ready), .overrun(e_ovr)
    );

    nibble_parity_rx #(.ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sin(sin),
        .out_data(o_data), .out_par_err(o_perr), .out_frm_err(o_ferr),
        .out_valid(o_valid), .out_ready(out_ready), .overrun(o_ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect sampled bits of a frame, then apply the buffer rules.
    int         m_nbits = 0;
    bit         m_bits[7];
    logic [3:0] m_data = 4'h0;
    logic       m_perr_e = 1'b0, m_perr_o = 1'b0, m_ferr = 1'b0, m_valid = 1'b0, m_ovr = 1'b0;

    always @(posedge clk) begin
        bit         done;
        logic [3:0] d;
        logic       x;
        if (!rst_n) begin
            m_nbits = 0; m_data = 4'h0; m_perr_e = 0; m_perr_o = 0;
            m_ferr = 0; m_valid = 0; m_ovr = 0;
        end else begin
            done  = 1'b0;
            m_ovr = 1'b0;
            if (bit_en) begin
                if (m_nbits == 0) begin
                    if (sin == 1'b0) begin
                        m_bits[0] = 1'b0;
                        m_nbits   = 1;
                    end
                end else begin
                    m_bits[m_nbits] = sin;
                    m_nbits++;
                    if (m_nbits == 7) begin
                        done    = 1'b1;
                        m_nbits = 0;
                    end
                end
            end
            if (done) begin
                if (!m_valid || out_ready) begin
                    d        = {m_bits[4], m_bits[3], m_bits[2], m_bits[1]};
                    x        = d[0] ^ d[1] ^ d[2] ^ d[3] ^ m_bits[5];
                    m_data   = d;
                    m_perr_e = (x != 1'b0);
                    m_perr_o = (x != 1'b1);
                    m_ferr   = !m_bits[6];
                    m_valid  = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("even_valid", 8'(e_valid), 8'(m_valid));
            chk("odd_valid",  8'(o_valid), 8'(m_valid));
            chk("even_ovr",   8'(e_ovr),   8'(m_ovr));
            chk("odd_ovr",    8'(o_ovr),   8'(m_ovr));
            chk("even_data",  8'(e_data),  8'(m_data));
            chk("odd_data",   8'(o_data),  8'(m_data));
            chk("even_perr",  8'(e_perr),  8'(m_perr_e));
            chk("odd_perr",   8'(o_perr),  8'(m_perr_o));
            chk("even_ferr",  8'(e_ferr),  8'(m_ferr));
            chk("odd_ferr",   8'(o_ferr),  8'(m_ferr));
        end
    end

    task automatic tick(input logic en, input logic s);
        bit_en = en;
        sin    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic pflip, input logic stop);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, d[i]);
        tick(1'b1, (^d) ^ pflip);
        tick(1'b1, stop);
    endtask

    // Every enabled bit is followed by a disabled edge carrying the opposite level.
    task automatic send_frame_slow(input logic [3:0] d);
        logic [6:0] bits;
        bits = {1'b1, ^d, d, 1'b0};
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, bits[i]);
            if (i != 6) tick(1'b0, ~bits[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        cmp_on = 1'b1;
        chk("rst_valid", 8'(e_valid), 8'h0);
        chk("rst_data",  8'(e_data),  8'h0);
        chk("rst_ovr",   8'(e_ovr),   8'h0);
        rst_n = 1'b1;
        tick(1'b1, 1'b1);

        out_ready = 1'b1;
        send_frame(4'hB, 1'b0, 1'b1);
        chk("b_data",     8'(e_data),  8'hB);
        chk("b_valid",    8'(e_valid), 8'h1);
        chk("b_perr",     8'(e_perr),  8'h0);
        chk("b_ferr",     8'(e_ferr),  8'h0);
        chk("b_odd_perr", 8'(o_perr),  8'h1);
        tick(1'b1, 1'b1);
        chk("b_drop", 8'(e_valid), 8'h0);

        send_frame(4'hB, 1'b1, 1'b1);
        chk("bflip_data",     8'(e_data), 8'hB);
        chk("bflip_perr",     8'(e_perr), 8'h1);
        chk("bflip_odd_perr", 8'(o_perr), 8'h0);
        tick(1'b1, 1'b1);

        send_frame(4'h0, 1'b0, 1'b0);
        chk("frm_data", 8'(e_data), 8'h0);
        chk("frm_perr", 8'(e_perr), 8'h0);
        chk("frm_ferr", 8'(e_ferr), 8'h1);
        tick(1'b1, 1'b1);
        send_frame(4'hA, 1'b0, 1'b1);
        chk("after_frm_data", 8'(e_data), 8'hA);
        chk("after_frm_ferr", 8'(e_ferr), 8'h0);
        tick(1'b1, 1'b1);

        out_ready = 1'b0;
        send_frame(4'h3, 1'b0, 1'b1);
        chk("ov_first_valid", 8'(e_valid), 8'h1);
        send_frame(4'h5, 1'b0, 1'b1);
        chk("ov_pulse", 8'(e_ovr),  8'h1);
        chk("ov_held",  8'(e_data), 8'h3);
        tick(1'b1, 1'b1);
        chk("ov_pulse_end", 8'(e_ovr),   8'h0);
        chk("ov_still",     8'(e_valid), 8'h1);
        out_ready = 1'b1;
        tick(1'b1, 1'b1);
        chk("ov_drained", 8'(e_valid), 8'h0);
        chk("ov_hold",    8'(e_data),  8'h3);

        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1);
            tick(1'b0, 1'b0);
        end
        chk("toggle_idle", 8'(e_valid), 8'h0);
        send_frame_slow(4'hC);
        chk("slow_data",  8'(e_data),  8'hC);
        chk("slow_valid", 8'(e_valid), 8'h1);
        chk("slow_perr",  8'(e_perr),  8'h0);
        tick(1'b1, 1'b1);

        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        rst_n = 1'b0;
        tick(1'b1, 1'b0);
        rst_n = 1'b1;
        chk("abort_valid", 8'(e_valid), 8'h0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);
        chk("abort_quiet", 8'(e_valid), 8'h0);
        send_frame(4'h6, 1'b0, 1'b1);
        chk("six_data",  8'(e_data),  8'h6);
        chk("six_valid", 8'(e_valid), 8'h1);
        chk("six_perr",  8'(e_perr),  8'h0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);

        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
